// File: rtl/shift_ex_pipe.sv
// rtl/shift_ex_pipe.sv - two-stage execute wrapper around the MIPS32 barrel shifter
module shift_ex_pipe #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       funct,
  input  logic             rot,
  input  logic [4:0]       shamt,
  input  logic [31:0]      rs_val,
  input  logic [31:0]      rt_val,
  input  logic [4:0]       rd_addr,
  input  logic             flush,
  output logic [31:0]      Shift_in,
  output logic [4:0]       Shift_amount,
  output logic [1:0]       Shift_op,
  input  logic [31:0]      Shift_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [4:0]       out_rd,
  output logic             out_err,
  output logic [CNT_W-1:0] op_count
);

  logic        s1_valid, s2_valid;
  logic [31:0] s1_rt;
  logic [4:0]  s1_amt, s1_rd;
  logic [1:0]  s1_op;
  logic        s1_err;
  logic [31:0] s2_data;
  logic [4:0]  s2_rd;
  logic        s2_err;

  logic [1:0]  dec_op;
  logic [4:0]  dec_amt;
  logic        dec_err;
  logic        s2_free, s1_adv, s1_load, fire;

  // Unsupported functs pass rt through unchanged (SLL by 0) and flag an error.
  always_comb begin
    dec_op  = 2'b00;
    dec_amt = 5'd0;
    dec_err = 1'b0;
    case (funct)
      6'b000000: begin dec_op = 2'b00;                  dec_amt = shamt;       end
      6'b000010: begin dec_op = rot ? 2'b11 : 2'b01;    dec_amt = shamt;       end
      6'b000011: begin dec_op = 2'b10;                  dec_amt = shamt;       end
      6'b000100: begin dec_op = 2'b00;                  dec_amt = rs_val[4:0]; end
      6'b000110: begin dec_op = rot ? 2'b11 : 2'b01;    dec_amt = rs_val[4:0]; end
      6'b000111: begin dec_op = 2'b10;                  dec_amt = rs_val[4:0]; end
      default:   dec_err = 1'b1;
    endcase
  end

  assign s2_free  = !s2_valid || out_ready;
  assign s1_adv   = s1_valid && s2_free;
  assign in_ready = !s1_valid || s2_free;
  assign s1_load  = in_valid && in_ready && !flush;
  assign fire     = s2_valid && out_ready;

  assign Shift_in     = s1_rt;
  assign Shift_amount = s1_amt;
  assign Shift_op     = s1_op;
  assign out_valid    = s2_valid;
  assign out_data     = s2_data;
  assign out_rd       = s2_rd;
  assign out_err      = s2_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_rt    <= '0;
      s1_amt   <= '0;
      s1_rd    <= '0;
      s1_op    <= '0;
      s1_err   <= 1'b0;
    end else begin
      if (flush)        s1_valid <= 1'b0;
      else if (s1_load) s1_valid <= 1'b1;
      else if (s1_adv)  s1_valid <= 1'b0;
      if (s1_load) begin
        s1_rt  <= rt_val;
        s1_amt <= dec_amt;
        s1_rd  <= rd_addr;
        s1_op  <= dec_op;
        s1_err <= dec_err;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_rd    <= '0;
      s2_err   <= 1'b0;
    end else begin
      if (flush)          s2_valid <= 1'b0;
      else if (s1_adv)    s2_valid <= 1'b1;
      else if (out_ready) s2_valid <= 1'b0;
      if (s1_adv) begin
        s2_data <= Shift_out;
        s2_rd   <= s1_rd;
        s2_err  <= s1_err;
      end
    end
  end

  // Saturating handoff counter; a handoff in a flush cycle still counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      op_count <= '0;
    else if (fire && (op_count != {CNT_W{1'b1}}))
      op_count <= op_count + {{(CNT_W-1){1'b0}}, 1'b1};
  end

endmodule

// File: tb/tb_shift_ex_pipe.sv
// tb/tb_shift_ex_pipe.sv - directed self-checking bench for shift_ex_pipe
module tb_shift_ex_pipe;

  logic        clk = 1'b0;
  logic        rst, in_valid, rot, flush, out_ready;
  logic [5:0]  funct;
  logic [4:0]  shamt, rd_addr;
  logic [31:0] rs_val, rt_val;

  logic        in_ready, out_valid, out_err;
  logic [31:0] shift_in_a, shift_out_a, out_data;
  logic [4:0]  shift_amt_a, out_rd;
  logic [1:0]  shift_op_a;
  logic [15:0] op_count;

  logic        in_ready_b, out_valid_b, out_err_b;
  logic [31:0] shift_in_b, shift_out_b, out_data_b;
  logic [4:0]  shift_amt_b, out_rd_b;
  logic [1:0]  shift_op_b;
  logic [1:0]  op_count_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] shf(input logic [31:0] v, input logic [4:0] a, input logic [1:0] op);
    logic [63:0] dbl;
    dbl = {v, v} >> a;
    case (op)
      2'b00:   return v << a;
      2'b01:   return v >> a;
      2'b10:   return $unsigned($signed(v) >>> a);
      default: return dbl[31:0];
    endcase
  endfunction

  assign shift_out_a = shf(shift_in_a, shift_amt_a, shift_op_a);
  assign shift_out_b = shf(shift_in_b, shift_amt_b, shift_op_b);

  shift_ex_pipe #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .funct(funct), .rot(rot), .shamt(shamt), .rs_val(rs_val), .rt_val(rt_val),
    .rd_addr(rd_addr), .flush(flush),
    .Shift_in(shift_in_a), .Shift_amount(shift_amt_a), .Shift_op(shift_op_a),
    .Shift_out(shift_out_a),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_rd(out_rd), .out_err(out_err), .op_count(op_count)
  );

  shift_ex_pipe #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .funct(funct), .rot(rot), .shamt(shamt), .rs_val(rs_val), .rt_val(rt_val),
    .rd_addr(rd_addr), .flush(flush),
    .Shift_in(shift_in_b), .Shift_amount(shift_amt_b), .Shift_op(shift_op_b),
    .Shift_out(shift_out_b),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
    .out_rd(out_rd_b), .out_err(out_err_b), .op_count(op_count_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [5:0] f, input logic r, input logic [4:0] sa,
                        input logic [31:0] rs, input logic [31:0] rt, input logic [4:0] rd);
    funct = f; rot = r; shamt = sa; rs_val = rs; rt_val = rt; rd_addr = rd;
    in_valid = 1'b1;
    #1;
  endtask

  task automatic run_one(input string tag, input logic [5:0] f, input logic r, input logic [4:0] sa,
                         input logic [31:0] rs, input logic [31:0] rt, input logic [4:0] rd,
                         input logic [31:0] exp_data, input logic exp_err);
    set_op(f, r, sa, rs, rt, rd);
    check({tag, "_in_ready"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
    #1;
    check({tag, "_s1_no_out"}, out_valid, 0);
    tick();
    check({tag, "_out_valid"}, out_valid, 1);
    check({tag, "_out_data"}, out_data, exp_data);
    check({tag, "_out_rd"}, out_rd, rd);
    check({tag, "_out_err"}, out_err, exp_err);
    tick();
    check({tag, "_drained"}, out_valid, 0);
  endtask

  logic [5:0]  t3_f   [4] = '{6'b000000, 6'b000010, 6'b000011, 6'b000100};
  logic [4:0]  t3_sa  [4] = '{5'd1, 5'd4, 5'd8, 5'd0};
  logic [31:0] t3_rs  [4] = '{32'd0, 32'd0, 32'd0, 32'd31};
  logic [31:0] t3_rt  [4] = '{32'h3, 32'h100, 32'hFFFF_0000, 32'h1};
  logic [31:0] t3_exp [4] = '{32'h6, 32'h10, 32'hFFFF_FF00, 32'h8000_0000};

  initial begin
    int k, n;
    logic acc, fire;
    rst = 1'b1; in_valid = 1'b0; rot = 1'b0; flush = 1'b0; out_ready = 1'b1;
    funct = '0; shamt = '0; rs_val = '0; rt_val = '0; rd_addr = '0;
    #3;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_rd", out_rd, 0);
    check("rst_out_err", out_err, 0);
    check("rst_shift_in", shift_in_a, 0);
    check("rst_shift_amt", shift_amt_a, 0);
    check("rst_shift_op", shift_op_a, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_op_count", op_count, 0);
    tick();
    rst = 1'b0;

    // basic ops, one at a time
    run_one("sll", 6'b000000, 1'b0, 5'd4, 32'd0, 32'h1, 5'd7, 32'h10, 1'b0);
    check("sll_count", op_count, 1);
    run_one("srav", 6'b000111, 1'b0, 5'd0, 32'h23, 32'h8000_0000, 5'd9, 32'hF000_0000, 1'b0);
    run_one("rotr", 6'b000010, 1'b1, 5'd4, 32'd0, 32'hF1, 5'd10, 32'h1000_000F, 1'b0);
    run_one("srlv", 6'b000110, 1'b0, 5'd0, 32'h24, 32'h8000_0000, 5'd11, 32'h0800_0000, 1'b0);
    run_one("badf", 6'b100000, 1'b1, 5'd7, 32'd5, 32'hDEAD_BEEF, 5'd12, 32'hDEAD_BEEF, 1'b1);
    check("count5", op_count, 5);

    rst = 1'b1; #2; rst = 1'b0; #1;

    // back-to-back with downstream stalled, then released
    out_ready = 1'b0;
    k = 0; n = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (cyc == 3) out_ready = 1'b1;
      in_valid = (k < 4);
      if (k < 4) begin
        funct = t3_f[k]; rot = 1'b0; shamt = t3_sa[k]; rs_val = t3_rs[k];
        rt_val = t3_rt[k]; rd_addr = 5'(k + 1);
      end
      #1;
      if (cyc == 2) check("fill_in_ready", in_ready, 0);
      if (cyc == 2) check("fill_hold_data", out_data, 32'h6);
      acc  = in_valid && in_ready;
      fire = out_valid && out_ready;
      if (fire) begin
        if (n < 4) begin
          check("b2b_data", out_data, t3_exp[n]);
          check("b2b_rd", out_rd, 5'(n + 1));
        end
        n++;
      end
      tick();
      if (acc) k++;
    end
    in_valid = 1'b0;
    check("b2b_results", n, 4);
    check("b2b_count", op_count, 4);

    // flush with both stages full, concurrent input dropped
    out_ready = 1'b0;
    set_op(6'b000000, 1'b0, 5'd1, 32'd0, 32'h5, 5'd1);
    tick();
    set_op(6'b000000, 1'b0, 5'd2, 32'd0, 32'h5, 5'd2);
    tick();
    check("pre_flush_in_ready", in_ready, 0);
    check("pre_flush_valid", out_valid, 1);
    flush = 1'b1;
    set_op(6'b000000, 1'b0, 5'd3, 32'd0, 32'h5, 5'd3);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    check("flush_out_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 1);
    out_ready = 1'b1;
    tick();
    check("flush_dropped", out_valid, 0);
    tick();
    check("flush_dropped2", out_valid, 0);
    check("flush_count", op_count, 4);

    // asynchronous reset mid-stream
    out_ready = 1'b0;
    set_op(6'b000000, 1'b0, 5'd4, 32'd0, 32'h3, 5'd5);
    tick();
    set_op(6'b000000, 1'b0, 5'd1, 32'd0, 32'h3, 5'd6);
    tick();
    in_valid = 1'b0;
    check("pre_arst_data", out_data, 32'h30);
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_out_data", out_data, 0);
    check("arst_out_rd", out_rd, 0);
    check("arst_shift_in", shift_in_a, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_op_count", op_count, 0);
    #1;
    rst = 1'b0;

    // five handoffs: wide counter reaches 5, 2-bit counter saturates at 3
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_op(6'b000000, 1'b0, 5'd1, 32'd0, 32'(i + 1), 5'(i));
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
    check("sat_wide_count", op_count, 5);
    check("sat_narrow_count", op_count_b, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
